// File: rtl/dummy_l2.sv
// Simulated L2 responder: answers read/write line requests from the bus
// controller after a fixed number of busy cycles, with abort, error and
// asynchronous reset handling. Storage is a DEPTH x DATA_WIDTH line array.
module dummy_l2 #(
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 4,
  parameter int DEPTH      = 256
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  l2REN,
  input  logic                  l2WEN,
  input  logic [31:0]           l2addr,
  input  logic [DATA_WIDTH-1:0] l2store,
  output logic [DATA_WIDTH-1:0] l2load,
  output logic [1:0]            l2state
);

  // Response states, encoded in l2_state_t order
  localparam logic [1:0] L2_FREE   = 2'd0;
  localparam logic [1:0] L2_BUSY   = 2'd1;
  localparam logic [1:0] L2_ACCESS = 2'd2;
  localparam logic [1:0] L2_ERROR  = 2'd3;

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
  // Byte address limit: 8-byte lines, so DEPTH*8 bytes are addressable
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd8;

  logic [1:0]            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  wr_reg, wr_next;
  logic [DATA_WIDTH-1:0] load_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic req_any, req_valid, abort, finish_busy, mem_we, load_en;

  assign req_any     = l2REN | l2WEN;
  assign req_valid   = (l2REN ^ l2WEN) && (l2addr[2:0] == 3'b000) &&
                       ({1'b0, l2addr} < ADDR_LIMIT);
  // Dropping both enables while busy cancels the outstanding access
  assign abort       = (state_reg == L2_BUSY) && !req_any;
  assign finish_busy = (state_reg == L2_BUSY) && !abort && (cnt_reg == 4'd0);
  assign mem_we      = finish_busy && wr_reg;
  assign load_en     = finish_busy && !wr_reg;

  // Next-state logic; the request is latched only when accepted in FREE
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    wr_next    = wr_reg;
    case (state_reg)
      L2_FREE: begin
        if (req_any) begin
          if (req_valid) begin
            state_next = L2_BUSY;
            cnt_next   = CNT_INIT;
            idx_next   = l2addr[3 +: IDX_W];
            data_next  = l2store;
            wr_next    = l2WEN;
          end else begin
            state_next = L2_ERROR;
          end
        end
      end
      L2_BUSY: begin
        if (abort) begin
          state_next = L2_FREE;
        end else if (cnt_reg == 4'd0) begin
          state_next = L2_ACCESS;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = L2_FREE;
    endcase
  end

  // Control and latched-request registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= L2_FREE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      data_reg  <= '0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
    end
  end

  // Read data register: loads on the edge entering a read ACCESS, else holds
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_reg <= '0;
    end else if (load_en) begin
      load_reg <= mem[idx_reg];
    end
  end

  // Line storage: cleared by reset, written on the edge entering a write ACCESS
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx_reg] <= data_reg;
    end
  end

  assign l2load  = load_reg;
  assign l2state = state_reg;

endmodule

// File: tb/tb_dummy_l2.sv
// Self-checking bench for dummy_l2: per-scenario tasks, a line model and a
// queue of expected read data popped when the DUT enters ACCESS.
module tb_dummy_l2;

  localparam int DW      = 64;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 256;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          l2REN = 1'b0;
  logic          l2WEN = 1'b0;
  logic [31:0]   l2addr = '0;
  logic [DW-1:0] l2store = '0;
  logic [DW-1:0] l2load;
  logic [1:0]    l2state;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_load;
  int checks = 0;
  int passed = 0;

  dummy_l2 #(.DATA_WIDTH(DW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .l2REN(l2REN), .l2WEN(l2WEN),
    .l2addr(l2addr), .l2store(l2store), .l2load(l2load), .l2state(l2state)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_load = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_model();
    step();
    step();
    checks++;
    if (l2state !== S_FREE) $display("FAIL reset_state: got %0d want %0d", l2state, S_FREE);
    else passed++;
    checks++;
    if (l2load !== '0) $display("FAIL reset_load: got %h want 0", l2load);
    else passed++;
    #2 nRST = 1'b1;
  endtask

  // Full valid transaction: LATENCY BUSY cycles, one ACCESS, then FREE
  task automatic txn(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [DW-1:0] data, input string name);
    logic [7:0] idx;
    logic [DW-1:0] want;
    idx = addr[10:3];
    l2REN = ren; l2WEN = wen; l2addr = addr; l2store = data;
    if (ren) exp_q.push_back(model[idx]);
    for (int c = 0; c < LATENCY; c++) begin
      step();
      checks++;
      if (l2state !== S_BUSY) $display("FAIL %s_busy%0d: got %0d want %0d", name, c, l2state, S_BUSY);
      else passed++;
    end
    step();
    checks++;
    if (l2state !== S_ACCESS) $display("FAIL %s_access: got %0d want %0d", name, l2state, S_ACCESS);
    else passed++;
    if (ren) begin
      if (exp_q.size() == 0) want = 'x;
      else want = exp_q.pop_front();
      exp_load = want;
    end else begin
      model[idx] = data;
    end
    checks++;
    if (l2load !== exp_load) $display("FAIL %s_load: got %h want %h", name, l2load, exp_load);
    else passed++;
    l2REN = 1'b0; l2WEN = 1'b0;
    step();
    checks++;
    if (l2state !== S_FREE || l2load !== exp_load)
      $display("FAIL %s_after: state %0d load %h want state %0d load %h", name, l2state, l2load, S_FREE, exp_load);
    else passed++;
    $display("txn %s: %s addr=%h data=%h load=%h", name, ren ? "RD" : "WR", addr, ren ? exp_load : data, l2load);
  endtask

  // Invalid request: one ERROR cycle then FREE, storage and load untouched
  task automatic err_txn(input logic ren, input logic wen, input logic [31:0] addr, input string name);
    l2REN = ren; l2WEN = wen; l2addr = addr; l2store = 64'h1234_5678_9ABC_DEF0;
    step();
    checks++;
    if (l2state !== S_ERROR) $display("FAIL %s_error: got %0d want %0d", name, l2state, S_ERROR);
    else passed++;
    l2REN = 1'b0; l2WEN = 1'b0;
    step();
    checks++;
    if (l2state !== S_FREE || l2load !== exp_load)
      $display("FAIL %s_after: state %0d load %h want state %0d load %h", name, l2state, l2load, S_FREE, exp_load);
    else passed++;
    $display("txn %s: error addr=%h", name, addr);
  endtask

  task automatic test_basic();
    txn(1'b1, 1'b0, 32'h10, '0, "rd10_initial");
    txn(1'b0, 1'b1, 32'h18, 64'hDEADBEEF_CAFEF00D, "wr18");
    txn(1'b1, 1'b0, 32'h18, '0, "rd18");
    txn(1'b1, 1'b0, 32'h10, '0, "rd10_still0");
    txn(1'b0, 1'b1, 32'h7F8, 64'h0123_4567_89AB_CDEF, "wr_top");
    txn(1'b1, 1'b0, 32'h7F8, '0, "rd_top");
  endtask

  task automatic test_errors();
    err_txn(1'b1, 1'b0, 32'h0C, "misaligned");
    err_txn(1'b1, 1'b1, 32'h18, "both_en");
    err_txn(1'b1, 1'b0, 32'h800, "out_of_range");
    err_txn(1'b0, 1'b1, 32'h800, "wr_out_of_range");
    txn(1'b1, 1'b0, 32'h18, '0, "rd18_after_err");
  endtask

  task automatic test_abort();
    l2REN = 1'b0; l2WEN = 1'b1; l2addr = 32'h20; l2store = 64'h1111_2222_3333_4444;
    step();
    step();
    l2WEN = 1'b0;
    step();
    checks++;
    if (l2state !== S_FREE || l2load !== exp_load)
      $display("FAIL abort_free: state %0d load %h want state %0d load %h", l2state, l2load, S_FREE, exp_load);
    else passed++;
    $display("txn abort: WR addr=00000020 cancelled");
    txn(1'b1, 1'b0, 32'h20, '0, "rd20_after_abort");
  endtask

  task automatic test_reset_mid_busy();
    l2REN = 1'b0; l2WEN = 1'b1; l2addr = 32'h28; l2store = 64'h5555_6666_7777_8888;
    step();
    step();
    step();
    #2 nRST = 1'b0;
    #1;
    clear_model();
    checks++;
    if (l2state !== S_FREE || l2load !== '0)
      $display("FAIL reset_mid_busy: state %0d load %h want state %0d load 0", l2state, l2load, S_FREE);
    else passed++;
    l2WEN = 1'b0;
    #1 nRST = 1'b1;
    $display("txn reset_mid_busy: WR addr=00000028 cancelled");
    txn(1'b1, 1'b0, 32'h28, '0, "rd28_after_reset");
    txn(1'b1, 1'b0, 32'h18, '0, "rd18_cleared");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    txn(1'b0, 1'b1, 32'h18, 64'hAAAA_BBBB_CCCC_DDDD, "wr18_b2b");
    txn(1'b0, 1'b1, 32'h10, 64'h9999_8888_7777_6666, "wr10_b2b");
    l2REN = 1'b1; l2WEN = 1'b0; l2addr = 32'h18;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(model[3]);
      for (int c = 0; c < LATENCY; c++) begin
        step();
        checks++;
        if (l2state !== S_BUSY) $display("FAIL b2b%0d_busy%0d: got %0d want %0d", r, c, l2state, S_BUSY);
        else passed++;
        if (r == 1 && c == 1) l2addr = 32'h10;
      end
      step();
      checks++;
      if (l2state !== S_ACCESS) $display("FAIL b2b%0d_access: got %0d want %0d", r, l2state, S_ACCESS);
      else passed++;
      if (exp_q.size() == 0) want = 'x;
      else want = exp_q.pop_front();
      exp_load = want;
      checks++;
      if (l2load !== want) $display("FAIL b2b%0d_load: got %h want %h", r, l2load, want);
      else passed++;
      if (r == 1) begin
        l2REN = 1'b0;
      end
      step();
      checks++;
      if (l2state !== S_FREE) $display("FAIL b2b%0d_free: got %0d want %0d", r, l2state, S_FREE);
      else passed++;
      $display("txn b2b%0d: RD addr=00000018 load=%h", r, l2load);
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_abort();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
